input_interface: RTL and testbench

Byte-stream to frame-buffer writer. It accepts 8-bit colour bytes from the UART receiver, packs each R,G,B triplet into one 18-bit pixel (6 bits per colour) and writes the pixels sequentially into the image BRAM. The VGA-side reader fetches pixels from the same BRAM, so this block fills addresses 0..H_SIZE*V_SIZE-1 in the layout that reader expects.

---
 rtl/image_pkg.sv | 26 ++
 rtl/input_interface_if.sv | 40 ++++
 rtl/input_interface_byte_timeout.sv | 33 +++
 rtl/input_interface.sv | 121 ++++++++++++
 tb/tb_input_interface.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/image_pkg.sv
// Shared frame-buffer geometry, widths and rx byte-state type.
// Used by both the UART-side writer and the VGA-side reader.
package image_pkg;

    localparam int H_SIZE         = 607;
    localparam int V_SIZE         = 455;
    localparam int TIMEOUT_CYCLES = 1_000_000;

    localparam int ADDR_W  = 19;
    localparam int PIXEL_W = 18;
    localparam int COLOR_W = 6;

    typedef enum logic [1:0] {
        GET_R,
        GET_G,
        GET_B
    } rx_state_t;

    // Upper bits of a received byte; no rounding.
    function automatic logic [COLOR_W-1:0] trunc_color(
        input logic [7:0] b
    );
        return b[7 -: COLOR_W];
    endfunction

endpackage

// File: rtl/input_interface_if.sv
// Byte-in / BRAM-write bundle of the frame-buffer writer.
// master drives bytes and sync; slave is the writer itself.
interface input_interface_if;
    import image_pkg::*;

    logic [7:0]         rx_data;
    logic               rx_ready;
    logic               frame_sync;
    logic [ADDR_W-1:0]  w_address;
    logic [PIXEL_W-1:0] w_data;
    logic               w_enable;
    logic               busy;
    logic               frame_done;
    logic               pixel_dropped;

    modport master (
        output rx_data,
        output rx_ready,
        output frame_sync,
        input  w_address,
        input  w_data,
        input  w_enable,
        input  busy,
        input  frame_done,
        input  pixel_dropped
    );

    modport slave (
        input  rx_data,
        input  rx_ready,
        input  frame_sync,
        output w_address,
        output w_data,
        output w_enable,
        output busy,
        output frame_done,
        output pixel_dropped
    );

endinterface

// File: rtl/input_interface_byte_timeout.sv
// Inter-byte idle counter; expired strobes on the last allowed
// idle cycle unless cleared in that same cycle.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);
    assign expired = enable && !clear && at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/input_interface.sv
// Packs R,G,B bytes into 18-bit pixels and writes them
// sequentially into the image BRAM, wrapping at end of frame.
module input_interface
    import image_pkg::*;
#(
    parameter int H_SIZE         = image_pkg::H_SIZE,
    parameter int V_SIZE         = image_pkg::V_SIZE,
    parameter int TIMEOUT_CYCLES = image_pkg::TIMEOUT_CYCLES
) (
    input logic         clk,
    input logic         reset,
    input_interface_if.slave bus
);

    localparam int PIXELS = H_SIZE * V_SIZE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    if (PIXELS > (1 << ADDR_W)) begin : g_size_check
        $error("input_interface: H_SIZE*V_SIZE exceeds address space");
    end

    rx_state_t          state;
    rx_state_t          state_nxt;
    logic [COLOR_W-1:0] r_reg;
    logic [COLOR_W-1:0] g_reg;
    logic [COLOR_W-1:0] color;
    logic [ADDR_W-1:0]  w_address;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [PIXEL_W-1:0] w_data;
    logic               w_enable;
    logic               frame_done;
    logic               pixel_dropped;
    logic               accept;
    logic               write;
    logic               busy;
    logic               to_clear;
    logic               expired;

    assign color  = trunc_color(bus.rx_data);
    assign accept = bus.rx_ready && !bus.frame_sync;
    assign busy   = (state != GET_R);

    assign to_clear = bus.rx_ready || bus.frame_sync || !busy;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (to_clear),
        .enable (busy),
        .expired(expired)
    );

    always_comb begin
        state_nxt = state;
        write     = 1'b0;
        unique case (state)
            GET_R: begin
                if (accept) state_nxt = GET_G;
            end
            GET_G: begin
                if (accept)       state_nxt = GET_B;
                else if (expired) state_nxt = GET_R;
            end
            GET_B: begin
                if (accept) begin
                    state_nxt = GET_R;
                    write     = 1'b1;
                end else if (expired) begin
                    state_nxt = GET_R;
                end
            end
            default: state_nxt = GET_R;
        endcase
        if (bus.frame_sync) state_nxt = GET_R;
    end

    // Increment lands one cycle after the write; sync overrides it.
    always_comb begin
        addr_nxt = w_address;
        if (bus.frame_sync) begin
            addr_nxt = '0;
        end else if (w_enable) begin
            addr_nxt = (w_address == LAST_ADDR) ? '0 : w_address + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= GET_R;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg         <= '0;
            g_reg         <= '0;
            w_data        <= '0;
            w_address     <= '0;
            w_enable      <= 1'b0;
            frame_done    <= 1'b0;
            pixel_dropped <= 1'b0;
        end else begin
            w_enable      <= write;
            frame_done    <= write && (addr_nxt == LAST_ADDR);
            pixel_dropped <= expired;
            w_address     <= addr_nxt;
            if (accept && state == GET_R) r_reg <= color;
            if (accept && state == GET_G) g_reg <= color;
            if (write) w_data <= {r_reg, g_reg, color};
        end
    end

    assign bus.w_address     = w_address;
    assign bus.w_data        = w_data;
    assign bus.w_enable      = w_enable;
    assign bus.busy          = busy;
    assign bus.frame_done    = frame_done;
    assign bus.pixel_dropped = pixel_dropped;

endmodule

// File: tb/tb_input_interface.sv
// Self-checking bench for input_interface on a 4x2 frame with a
// 16-cycle byte timeout, using a pixel-level reference model.
module tb_input_interface;
    import image_pkg::*;

    localparam int H = 4;
    localparam int V = 2;
    localparam int P = H * V;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    input_interface_if bus();

    input_interface #(
        .H_SIZE(H),
        .V_SIZE(V),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes held, idle count, next write slot.
    int          m_nb;
    int          m_idle;
    int          m_addr;
    logic [7:0]  m_b [3];
    logic        m_we;
    logic        m_fd;
    logic        m_drop;
    logic [17:0] m_data;

    function automatic logic [5:0] c6(input logic [7:0] b);
        return 6'(b / 8'd4);
    endfunction

    task automatic model_reset();
        m_nb   = 0;
        m_idle = 0;
        m_addr = 0;
        m_we   = 1'b0;
        m_fd   = 1'b0;
        m_drop = 1'b0;
        m_data = '0;
    endtask

    task automatic step(input logic rx, input logic [7:0] d,
                        input logic fs);
        @(negedge clk);
        bus.rx_ready   = rx;
        bus.rx_data    = rx ? d : 8'($urandom);
        bus.frame_sync = fs;
        @(posedge clk);
        if (fs) begin
            m_addr = 0;
            m_nb   = 0;
            m_idle = 0;
            m_we   = 1'b0;
            m_fd   = 1'b0;
            m_drop = 1'b0;
        end else begin
            if (m_we) m_addr = (m_addr + 1) % P;
            m_we   = 1'b0;
            m_fd   = 1'b0;
            m_drop = 1'b0;
            if (rx) begin
                m_b[m_nb] = d;
                m_idle    = 0;
                if (m_nb == 2) begin
                    m_we   = 1'b1;
                    m_data = {c6(m_b[0]), c6(m_b[1]), c6(d)};
                    m_fd   = (m_addr == P - 1);
                    m_nb   = 0;
                end else begin
                    m_nb = m_nb + 1;
                end
            end else if (m_nb > 0) begin
                if (m_idle == T - 1) begin
                    m_drop = 1'b1;
                    m_nb   = 0;
                    m_idle = 0;
                end else begin
                    m_idle = m_idle + 1;
                end
            end
        end
        #1;
        checks++;
        if (bus.w_enable !== m_we || bus.frame_done !== m_fd ||
            bus.pixel_dropped !== m_drop ||
            bus.busy !== (m_nb != 0) ||
            bus.w_address !== 19'(m_addr) ||
            bus.w_data !== m_data) begin
            errors++;
            $display("FAIL model t=%0t we=%b/%b fd=%b/%b drop=%b/%b busy=%b/%b addr=%0d/%0d data=%h/%h (got/exp)",
                     $time, bus.w_enable, m_we, bus.frame_done, m_fd,
                     bus.pixel_dropped, m_drop, bus.busy, (m_nb != 0),
                     bus.w_address, m_addr, bus.w_data, m_data);
        end
        bus.rx_ready   = 1'b0;
        bus.frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.w_enable !== 1'b0 || bus.busy !== 1'b0 ||
            bus.w_address !== '0 || bus.w_data !== '0 ||
            bus.frame_done !== 1'b0 || bus.pixel_dropped !== 1'b0) begin
            errors++;
            $display("FAIL reset_state we=%b busy=%b addr=%0d data=%h fd=%b drop=%b (exp all 0)",
                     bus.w_enable, bus.busy, bus.w_address, bus.w_data,
                     bus.frame_done, bus.pixel_dropped);
        end
    endtask

    task automatic test_single_pixel();
        step(1'b1, 8'hFC, 1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_r got=%b exp=1", bus.busy);
        end
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'h07, 1'b0);
        checks++;
        if (bus.w_enable !== 1'b1 || bus.w_address !== 19'd0 ||
            bus.w_data !== 18'b111111_100000_000001) begin
            errors++;
            $display("FAIL first_pixel we=%b addr=%0d data=%b exp we=1 addr=0 data=111111100000000001",
                     bus.w_enable, bus.w_address, bus.w_data);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.w_address !== 19'd1 || bus.w_enable !== 1'b0) begin
            errors++;
            $display("FAIL addr_incr addr=%0d we=%b exp addr=1 we=0",
                     bus.w_address, bus.w_enable);
        end
    endtask

    task automatic test_back_to_back();
        int addrs[$];
        int fd_n;
        int fd_addr;
        fd_n    = 0;
        fd_addr = -1;
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3 * P; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            if (bus.w_enable) addrs.push_back(int'(bus.w_address));
            if (bus.frame_done) begin
                fd_n++;
                fd_addr = int'(bus.w_address);
            end
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (addrs.size() != P) begin
            errors++;
            $display("FAIL b2b_writes got=%0d exp=%0d", addrs.size(), P);
        end else begin
            for (int i = 0; i < P; i++) begin
                checks++;
                if (addrs[i] != i) begin
                    errors++;
                    $display("FAIL b2b_addr idx=%0d got=%0d exp=%0d",
                             i, addrs[i], i);
                end
            end
        end
        checks++;
        if (fd_n != 1 || fd_addr != P - 1) begin
            errors++;
            $display("FAIL frame_done count=%0d addr=%0d exp count=1 addr=%0d",
                     fd_n, fd_addr, P - 1);
        end
        checks++;
        if (bus.w_address !== 19'd0) begin
            errors++;
            $display("FAIL wrap addr=%0d exp=0", bus.w_address);
        end
    endtask

    task automatic test_timeout();
        int drops;
        int wr;
        logic [18:0] a0;
        drops = 0;
        wr    = 0;
        a0    = bus.w_address;
        step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < T; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (bus.pixel_dropped) drops++;
            if (bus.w_enable) wr++;
        end
        step(1'b0, 8'h00, 1'b0);
        if (bus.pixel_dropped) drops++;
        checks++;
        if (drops != 1 || wr != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop drops=%0d writes=%0d busy=%b exp 1 0 0",
                     drops, wr, bus.busy);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        checks++;
        if (bus.w_enable !== 1'b1 || bus.w_address !== a0) begin
            errors++;
            $display("FAIL after_drop we=%b addr=%0d exp we=1 addr=%0d",
                     bus.w_enable, bus.w_address, a0);
        end
    endtask

    task automatic test_expiry_race();
        int drops;
        drops = 0;
        step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < T - 1; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (bus.pixel_dropped) drops++;
        end
        step(1'b1, 8'($urandom), 1'b0);
        if (bus.pixel_dropped) drops++;
        checks++;
        if (drops != 0 || bus.w_enable !== 1'b1) begin
            errors++;
            $display("FAIL expiry_race drops=%0d we=%b exp 0 1",
                     drops, bus.w_enable);
        end
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_frame_sync();
        for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b1);
        checks++;
        if (bus.busy !== 1'b0 || bus.w_address !== 19'd0) begin
            errors++;
            $display("FAIL sync_byte busy=%b addr=%0d exp 0 0",
                     bus.busy, bus.w_address);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        checks++;
        if (bus.w_enable !== 1'b1 || bus.w_address !== 19'd0) begin
            errors++;
            $display("FAIL sync_first we=%b addr=%0d exp 1 0",
                     bus.w_enable, bus.w_address);
        end
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        checks++;
        if (bus.w_enable !== 1'b1 || bus.w_address !== 19'd1) begin
            errors++;
            $display("FAIL sync_we_write we=%b addr=%0d exp 1 1",
                     bus.w_enable, bus.w_address);
        end
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        checks++;
        if (bus.w_enable !== 1'b1 || bus.w_address !== 19'd0) begin
            errors++;
            $display("FAIL sync_in_we we=%b addr=%0d exp 1 0",
                     bus.w_enable, bus.w_address);
        end
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.w_enable !== 1'b0 || bus.busy !== 1'b0 ||
            bus.w_address !== '0 || bus.w_data !== '0 ||
            bus.frame_done !== 1'b0 || bus.pixel_dropped !== 1'b0) begin
            errors++;
            $display("FAIL async_reset we=%b busy=%b addr=%0d data=%h fd=%b drop=%b (exp all 0)",
                     bus.w_enable, bus.busy, bus.w_address, bus.w_data,
                     bus.frame_done, bus.pixel_dropped);
        end
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        bus.rx_ready = 1'b0;
        reset = 1'b0;
        model_reset();
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                repeat (T + 2) step(1'b0, 8'h00, 1'b0);
            end
            step($urandom_range(0, 1) == 1, 8'($urandom),
                 $urandom_range(0, 63) == 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_data    = 8'h00;
        bus.rx_ready   = 1'b0;
        bus.frame_sync = 1'b0;
        model_reset();
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_timeout();
        test_expiry_race();
        test_frame_sync();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
